// File: rtl/vid_pkg.sv
// Shared timing defaults and types for the monochrome frame-buffer scan-out path.
// Default geometry is 1024x768 with a 24576-word (32-bit) frame buffer.
package vid_pkg;

   localparam int H_ACTIVE_DEF = 1024;
   localparam int H_FP_DEF     = 24;
   localparam int H_SYNC_DEF   = 136;
   localparam int H_BP_DEF     = 160;
   localparam int V_ACTIVE_DEF = 768;
   localparam int V_FP_DEF     = 3;
   localparam int V_SYNC_DEF   = 6;
   localparam int V_BP_DEF     = 29;
   localparam bit SYNC_POL_DEF = 1'b0;

   localparam int H_TOTAL        = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL        = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int WORDS_PER_LINE = H_ACTIVE_DEF / 32;

   localparam int ADR_W  = 15;
   localparam int DATA_W = 32;

   // Per-pixel control flags carried down the alignment pipeline alongside the data.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic irq;
   } vid_flags_t;

   function automatic int span_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vid_timing.sv
// Horizontal/vertical raster counters and the stage-0 region flags derived from them.
// Sync flags here are "asserted" indications; the output polarity is applied downstream.
module vid_timing
   import vid_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int HCW      = $clog2(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int VCW      = $clog2(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic           clk,
   input  logic           rst,
   output logic [HCW-1:0] hcnt,
   output logic [VCW-1:0] vcnt,
   output logic           visible,
   output logic           hsync_act,
   output logic           vsync_act,
   output logic           frame_start,
   output logic           vblank_start,
   output logic           line_end
);

   localparam int LINE_LEN  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int FRAME_LEN = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // One extra bit so a sync window ending exactly at the total still compares correctly.
   localparam logic [HCW:0] HS_START = (HCW+1)'(H_ACTIVE + H_FP);
   localparam logic [HCW:0] HS_END   = (HCW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCW:0] VS_START = (VCW+1)'(V_ACTIVE + V_FP);
   localparam logic [VCW:0] VS_END   = (VCW+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic v_last;

   assign line_end = (hcnt == HCW'(LINE_LEN - 1));
   assign v_last   = (vcnt == VCW'(FRAME_LEN - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (line_end) begin
         hcnt <= '0;
         vcnt <= v_last ? '0 : vcnt + VCW'(1);
      end else begin
         hcnt <= hcnt + HCW'(1);
      end
   end

   assign visible      = (hcnt < HCW'(H_ACTIVE)) && (vcnt < VCW'(V_ACTIVE));
   assign hsync_act    = ({1'b0, hcnt} >= HS_START) && ({1'b0, hcnt} < HS_END);
   assign vsync_act    = ({1'b0, vcnt} >= VS_START) && ({1'b0, vcnt} < VS_END);
   assign frame_start  = (hcnt == '0) && (vcnt == '0);
   assign vblank_start = (hcnt == '0) && (vcnt == VCW'(V_ACTIVE));

endmodule

// File: rtl/vid_scan_ctrl.sv
// Scan-out controller: fetches frame-buffer words, serialises them LSB-first into pixels,
// and delays sync/de/irq by three clocks so every output lines up with pix.
module vid_scan_ctrl
   import vid_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = SYNC_POL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADR_W-1:0]  fb_base,
   output logic [ADR_W-1:0]  adr,
   input  logic [DATA_W-1:0] rdata,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              pix,
   output logic              vblank_irq
);

   localparam int HCW        = $clog2(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int VCW        = $clog2(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam int LINE_WORDS = H_ACTIVE / 32;

   logic [HCW-1:0]    hcnt;
   logic [VCW-1:0]    vcnt;
   logic              visible, hsync_act, vsync_act, frame_start, vblank_start, line_end;
   logic              en_q, en_eff, fetch;
   logic [ADR_W-1:0]  line_base, line_base_eff, word_idx;
   logic [1:0]        fetch_p;
   logic [DATA_W-1:0] shift;
   vid_flags_t        stage0;
   vid_flags_t [2:0]  pipe;

   vid_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HCW(HCW), .VCW(VCW)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .visible     (visible),
      .hsync_act   (hsync_act),
      .vsync_act   (vsync_act),
      .frame_start (frame_start),
      .vblank_start(vblank_start),
      .line_end    (line_end)
   );

   // The frame-start cycle itself fetches word 0, so it must see en/fb_base before they are latched.
   assign en_eff        = frame_start ? en : en_q;
   assign line_base_eff = frame_start ? fb_base : line_base;
   assign word_idx      = ADR_W'(hcnt >> 5);
   assign fetch         = visible && en_eff && (hcnt[4:0] == 5'd0);

   assign stage0 = '{de: visible && en_eff, hs: hsync_act, vs: vsync_act, irq: vblank_start};

   always_ff @(posedge clk) begin
      if (!rst) begin
         en_q      <= 1'b0;
         line_base <= '0;
         adr       <= '0;
         fetch_p   <= '0;
         shift     <= '0;
         pipe      <= '0;
      end else begin
         if (frame_start) begin
            en_q      <= en;
            line_base <= fb_base;
         end else if (line_end && (vcnt < VCW'(V_ACTIVE - 1))) begin
            line_base <= line_base + ADR_W'(LINE_WORDS);
         end
         if (fetch)
            adr <= line_base_eff + word_idx;
         // Read data returns two clocks after the fetch decision; load then, otherwise shift out.
         fetch_p <= {fetch_p[0], fetch};
         shift   <= fetch_p[1] ? rdata : {1'b0, shift[DATA_W-1:1]};
         pipe    <= {pipe[1:0], stage0};
      end
   end

   assign de         = pipe[2].de;
   assign pix        = pipe[2].de & shift[0];
   assign hsync      = SYNC_POL ? pipe[2].hs : ~pipe[2].hs;
   assign vsync      = SYNC_POL ? pipe[2].vs : ~pipe[2].vs;
   assign vblank_irq = pipe[2].irq;

endmodule
